mrx_assembler: RTL

MRX_ASSEMBLER -- requirements
Module: mrx_assembler

---
 rtl/mio_pkg.sv | 49 ++++
 rtl/emesh2packet.sv | 41 ++++
 rtl/mrx_assembler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mio_pkg.sv
// Shared constants and types for the MIO receive path: byte-valid patterns,
// emesh datamode encodings, assembler FSM states and packet field widths.
package mio_pkg;

    // IO byte-valid patterns recognised on the receive side
    localparam logic [7:0] VLD_B1 = 8'h01;
    localparam logic [7:0] VLD_B2 = 8'h03;
    localparam logic [7:0] VLD_B4 = 8'h0F;
    localparam logic [7:0] VLD_B6 = 8'h3F;
    localparam logic [7:0] VLD_B8 = 8'hFF;

    // Emesh datamode encodings (log2 of the transfer size in bytes)
    localparam logic [1:0] DM_BYTE   = 2'd0;
    localparam logic [1:0] DM_HALF   = 2'd1;
    localparam logic [1:0] DM_WORD   = 2'd2;
    localparam logic [1:0] DM_DOUBLE = 2'd3;

    // Meaningful packet width produced by emesh2packet for each address width
    localparam int unsigned EMESH_BASEW32 = 104;
    localparam int unsigned EMESH_BASEW64 = 136;

    // Emesh-mode beat tracking: IDLE expects beat 0, B1 beat 1, B2 beat 2
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B1   = 2'd1,
        ST_B2   = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic       ok;
        logic [1:0] dm;
    } dm_decode_t;

    // Streaming-mode valid pattern to datamode; ok=0 for any unsupported pattern
    function automatic dm_decode_t decode_valid(input logic [7:0] valid);
        dm_decode_t r;
        r.ok = 1'b1;
        r.dm = DM_BYTE;
        case (valid)
            VLD_B1:  r.dm = DM_BYTE;
            VLD_B2:  r.dm = DM_HALF;
            VLD_B4:  r.dm = DM_WORD;
            VLD_B8:  r.dm = DM_DOUBLE;
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/emesh2packet.sv
// Packs emesh transaction fields into the flat emesh packet layout:
//   [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr[31:0],
//   [71:40] data, [103:72] srcaddr, and for AW=64 [135:104] dstaddr[63:32].
// Bits above the meaningful width are zero.
module emesh2packet
    import mio_pkg::*;
#(
    parameter int AW = 32,
    parameter int PW = 104
) (
    input  logic          write_in,
    input  logic [1:0]    datamode_in,
    input  logic [4:0]    ctrlmode_in,
    input  logic [AW-1:0] dstaddr_in,
    input  logic [31:0]   data_in,
    input  logic [31:0]   srcaddr_in,
    output logic [PW-1:0] packet_out
);

    localparam int unsigned BASEW = (AW == 64) ? EMESH_BASEW64 : EMESH_BASEW32;
    localparam int unsigned CW    = (PW < BASEW) ? PW : BASEW;

    logic [BASEW-1:0] base;

    generate
        if (AW == 64) begin : g_aw64
            assign base = {dstaddr_in[AW-1:32], srcaddr_in, data_in,
                           dstaddr_in[31:0], ctrlmode_in, datamode_in, write_in};
        end else begin : g_aw32
            assign base = {srcaddr_in, data_in,
                           dstaddr_in[31:0], ctrlmode_in, datamode_in, write_in};
        end
    endgenerate

    // Place the packed fields at the bottom of the packet, zero above
    always_comb begin
        packet_out         = '0;
        packet_out[CW-1:0] = base[CW-1:0];
    end

endmodule

// File: rtl/mrx_assembler.sv
// Receive-side assembler: turns 64-bit IO beats into emesh packets.
// Streaming mode makes one packet per beat with an auto-incrementing
// destination address; emesh mode concatenates 2 (AW=32) or 3 (AW=64)
// raw beats into one packet. A single output register holds the packet
// until wait_in releases it.
module mrx_assembler
    import mio_pkg::*;
#(
    parameter int PW = 104,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          rx_en,
    input  logic          emode,
    input  logic [AW-1:0] cfg_base,
    input  logic [4:0]    cfg_ctrlmode,
    input  logic          io_access,
    input  logic [63:0]   io_packet,
    input  logic [7:0]    io_valid,
    output logic          io_wait,
    output logic          access_out,
    output logic [PW-1:0] packet_out,
    input  logic          wait_in,
    output logic          err
);

    localparam int unsigned NBEAT = (AW == 64) ? 3 : 2;
    localparam int unsigned BW    = 64 * NBEAT;

    rx_state_e     state_q, state_d;
    logic [BW-1:0] buffer_q, buffer_d;
    logic [AW-1:0] offset_q, offset_d;
    logic          access_q, access_d;
    logic [PW-1:0] packet_q, packet_d;
    logic          err_q, err_d;

    logic          beat_acc;
    logic          beat_live;
    logic          stream_sel;
    logic          stream_ok;
    logic          stream_bad;
    logic          emesh_live;
    logic          emesh_ok;
    logic          emesh_bad;
    logic          emesh_done;
    logic          pkt_done;
    dm_decode_t    dec;
    logic [7:0]    exp_valid;
    logic          last_beat;
    logic [1:0]    slot;
    logic [AW-1:0] stream_dst;
    logic [PW-1:0] stream_pkt;

    // The output register can only be refilled when it is empty or being
    // drained this cycle, so a final beat lands exactly as the old packet leaves.
    assign io_wait    = access_q & wait_in;
    assign beat_acc   = io_access & ~io_wait & rx_en;
    assign beat_live  = beat_acc & (io_valid != 8'h00);

    // emode only matters between packets; mid-packet beats stay in emesh mode
    assign stream_sel = (state_q == ST_IDLE) & ~emode;
    assign dec        = decode_valid(io_valid);
    assign stream_ok  = beat_live & stream_sel & dec.ok;
    assign stream_bad = beat_live & stream_sel & ~dec.ok;

    assign emesh_live = beat_live & ~stream_sel;
    assign emesh_ok   = emesh_live & (io_valid == exp_valid);
    assign emesh_bad  = emesh_live & (io_valid != exp_valid);
    assign emesh_done = emesh_ok & last_beat;
    assign pkt_done   = stream_ok | emesh_done;

    assign stream_dst = cfg_base + offset_q;

    emesh2packet #(
        .AW (AW),
        .PW (PW)
    ) u_emesh2packet (
        .write_in    (1'b1),
        .datamode_in (dec.dm),
        .ctrlmode_in (cfg_ctrlmode),
        .dstaddr_in  (stream_dst),
        .data_in     (io_packet[31:0]),
        .srcaddr_in  (io_packet[63:32]),
        .packet_out  (stream_pkt)
    );

    // FSM state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: advance on a correct emesh beat, abort on error or disable
    always_comb begin
        state_d = state_q;
        if (!rx_en || emesh_bad) begin
            state_d = ST_IDLE;
        end else if (emesh_ok) begin
            case (state_q)
                ST_IDLE: state_d = ST_B1;
                ST_B1:   state_d = (NBEAT == 3) ? ST_B2 : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: expected valid pattern, buffer slot and last-beat flag per state
    always_comb begin
        exp_valid = VLD_B8;
        last_beat = 1'b0;
        slot      = 2'd0;
        case (state_q)
            ST_IDLE: begin
                exp_valid = VLD_B8;
            end
            ST_B1: begin
                slot = 2'd1;
                if (NBEAT == 2) begin
                    exp_valid = VLD_B6;
                    last_beat = 1'b1;
                end
            end
            ST_B2: begin
                slot      = 2'd2;
                exp_valid = VLD_B2;
                last_beat = 1'b1;
            end
            default: begin
                exp_valid = VLD_B8;
            end
        endcase
    end

    // Beat buffer: write the accepted emesh beat into its 64-bit slot
    always_comb begin
        buffer_d = buffer_q;
        for (int unsigned k = 0; k < NBEAT; k++) begin
            if (emesh_ok && (int'(slot) == int'(k))) begin
                buffer_d[64*k +: 64] = io_packet;
            end
        end
    end

    // Streaming offset and sticky error; both clear while receive is disabled
    always_comb begin
        offset_d = offset_q;
        err_d    = err_q;
        if (!rx_en) begin
            offset_d = '0;
            err_d    = 1'b0;
        end else begin
            if (stream_ok) begin
                offset_d = offset_q + (AW'(1) << dec.dm);
            end
            if (stream_bad || emesh_bad) begin
                err_d = 1'b1;
            end
        end
    end

    // Output register: load on packet completion, hold under wait_in, else drain.
    // The final emesh beat is taken from buffer_d so it lands in the same cycle.
    always_comb begin
        access_d = access_q;
        packet_d = packet_q;
        if (pkt_done) begin
            access_d = 1'b1;
            packet_d = stream_ok ? stream_pkt : buffer_d[PW-1:0];
        end else if (!wait_in) begin
            access_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            buffer_q <= '0;
            offset_q <= '0;
            err_q    <= 1'b0;
            access_q <= 1'b0;
            packet_q <= '0;
        end else begin
            buffer_q <= buffer_d;
            offset_q <= offset_d;
            err_q    <= err_d;
            access_q <= access_d;
            packet_q <= packet_d;
        end
    end

    assign access_out = access_q;
    assign packet_out = packet_q;
    assign err        = err_q;

endmodule
